// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - screen sequencing, button hit-testing and HUD counters for the UI overlay
module game_flow_ctrl #(
    parameter int INV_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       click,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic       key_pulse,
    input  logic       light_pulse,
    input  logic       door_pulse,
    input  logic       hit_pulse,
    output logic [3:0] state,
    output logic [1:0] key_find,
    output logic [1:0] life,
    output logic [1:0] todo,
    output logic [3:0] play_valid
);

    typedef enum logic [3:0] {
        S_TITLE    = 4'd0,
        S_STAFF    = 4'd1,
        S_STAGE1   = 4'd2,
        S_SUCCESS1 = 4'd3,
        S_STAGE2   = 4'd4,
        S_SUCCESS2 = 4'd5,
        S_STAGE3   = 4'd6,
        S_SUCCESS3 = 4'd7,
        S_FAIL     = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        T_NONE       = 2'd0,
        T_FIND_KEY   = 2'd1,
        T_FIND_LIGHT = 2'd2,
        T_FIND_DOOR  = 2'd3
    } todo_t;

    localparam logic [25:0] INV_LOAD = 26'(INV_CYCLES - 1);

    state_t      state_q, state_d, enter_state;
    todo_t       todo_q, todo_d;
    logic [1:0]  key_q, key_d;
    logic [1:0]  life_q, life_d;
    logic [3:0]  pv_q, pv_d;
    logic [25:0] inv_q, inv_d;
    logic        btn_en;
    logic        hit_ok;
    logic        enter;

    function automatic logic in_y(input logic [8:0] y, input logic [8:0] lo, input logic [8:0] hi);
        return (y >= lo) && (y < hi);
    endfunction

    // Every button shares the same horizontal extent, so the x test is common.
    assign btn_en = click && (mouse_x >= 9'd120) && (mouse_x < 9'd200);
    assign hit_ok = hit_pulse && (state_q == S_STAGE3) && (inv_q == 26'd0);

    always_comb begin
        state_d     = state_q;
        todo_d      = todo_q;
        key_d       = key_q;
        life_d      = life_q;
        pv_d        = pv_q;
        inv_d       = (inv_q != 26'd0) ? inv_q - 26'd1 : inv_q;
        enter       = 1'b0;
        enter_state = S_STAGE1;

        case (state_q)
            S_TITLE: begin
                if (btn_en) begin
                    if (in_y(mouse_y, 9'd120, 9'd140)) begin
                        enter = 1'b1; enter_state = S_STAGE1;
                    end else if (in_y(mouse_y, 9'd160, 9'd180) && pv_q[2]) begin
                        enter = 1'b1; enter_state = S_STAGE2;
                    end else if (in_y(mouse_y, 9'd200, 9'd220) && pv_q[3]) begin
                        enter = 1'b1; enter_state = S_STAGE3;
                    end
                end
            end
            S_SUCCESS1, S_SUCCESS2: begin
                if (btn_en && in_y(mouse_y, 9'd140, 9'd160)) begin
                    enter       = 1'b1;
                    enter_state = (state_q == S_SUCCESS1) ? S_STAGE2 : S_STAGE3;
                end else if (btn_en && in_y(mouse_y, 9'd180, 9'd200)) begin
                    state_d = S_TITLE;
                end
            end
            S_SUCCESS3: begin
                if (btn_en && in_y(mouse_y, 9'd150, 9'd170))
                    state_d = S_STAFF;
            end
            S_FAIL: begin
                if (btn_en && in_y(mouse_y, 9'd140, 9'd160)) begin
                    enter = 1'b1; enter_state = S_STAGE3;
                end else if (btn_en && in_y(mouse_y, 9'd180, 9'd200)) begin
                    state_d = S_TITLE;
                end
            end
            S_STAFF: begin
                if (btn_en && in_y(mouse_y, 9'd180, 9'd200))
                    state_d = S_TITLE;
            end
            S_STAGE1, S_STAGE2, S_STAGE3: begin
                if (hit_ok && life_q == 2'd1) begin
                    // A fatal hit discards every other pulse of the same cycle.
                    state_d = S_FAIL;
                    todo_d  = T_NONE;
                    life_d  = 2'd0;
                    inv_d   = INV_LOAD;
                end else begin
                    if (hit_ok) begin
                        if (life_q != 2'd0)
                            life_d = life_q - 2'd1;
                        inv_d = INV_LOAD;
                    end
                    if (light_pulse && todo_q == T_FIND_LIGHT)
                        todo_d = T_FIND_KEY;
                    if (key_pulse && todo_q == T_FIND_KEY && key_q != 2'd3) begin
                        key_d = key_q + 2'd1;
                        if (key_q == 2'd2)
                            todo_d = T_FIND_DOOR;
                    end
                    // Door is judged against the pre-edge todo, so it cannot chain off the third key.
                    if (door_pulse && todo_q == T_FIND_DOOR) begin
                        todo_d = T_NONE;
                        if (state_q == S_STAGE1) begin
                            state_d = S_SUCCESS1;
                            pv_d[2] = 1'b1;
                        end else if (state_q == S_STAGE2) begin
                            state_d = S_SUCCESS2;
                            pv_d[3] = 1'b1;
                        end else begin
                            state_d = S_SUCCESS3;
                        end
                    end
                end
            end
            default: state_d = S_TITLE;
        endcase

        if (enter) begin
            state_d = enter_state;
            key_d   = 2'd0;
            life_d  = 2'd3;
            inv_d   = 26'd0;
            todo_d  = (enter_state == S_STAGE2) ? T_FIND_LIGHT : T_FIND_KEY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_TITLE;
            todo_q  <= T_NONE;
            key_q   <= 2'd0;
            life_q  <= 2'd0;
            pv_q    <= 4'b0010;
            inv_q   <= 26'd0;
        end else begin
            state_q <= state_d;
            todo_q  <= todo_d;
            key_q   <= key_d;
            life_q  <= life_d;
            pv_q    <= pv_d;
            inv_q   <= inv_d;
        end
    end

    assign state      = state_q;
    assign todo       = todo_q;
    assign key_find   = key_q;
    assign life       = life_q;
    assign play_valid = pv_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - scoreboard bench for game_flow_ctrl
module tb_game_flow_ctrl;

    logic       clk;
    logic       rst;
    logic       click;
    logic [8:0] mouse_x;
    logic [8:0] mouse_y;
    logic       key_pulse;
    logic       light_pulse;
    logic       door_pulse;
    logic       hit_pulse;
    logic [3:0] state;
    logic [1:0] key_find;
    logic [1:0] life;
    logic [1:0] todo;
    logic [3:0] play_valid;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] k;
        logic [1:0] l;
        logic [1:0] t;
        logic [3:0] pv;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] e_state;
    logic [1:0] e_key;
    logic [1:0] e_life;
    logic [1:0] e_todo;
    logic [3:0] e_pv;
    int         n_checks = 0;
    int         n_errors = 0;

    game_flow_ctrl #(.INV_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .click      (click),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .key_pulse  (key_pulse),
        .light_pulse(light_pulse),
        .door_pulse (door_pulse),
        .hit_pulse  (hit_pulse),
        .state      (state),
        .key_find   (key_find),
        .life       (life),
        .todo       (todo),
        .play_valid (play_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [8:0] x, input logic [8:0] y,
                         input logic k, input logic l, input logic d, input logic h,
                         input logic r, input string tag);
        exp_t e;
        @(negedge clk);
        click = c; mouse_x = x; mouse_y = y;
        key_pulse = k; light_pulse = l; door_pulse = d; hit_pulse = h; rst = r;
        sb.push_back('{e_state, e_key, e_life, e_todo, e_pv});
        @(posedge clk);
        #1;
        click = 1'b0; key_pulse = 1'b0; light_pulse = 1'b0;
        door_pulse = 1'b0; hit_pulse = 1'b0; rst = 1'b0;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".state"}, {4'd0, state}, {4'd0, e.st});
            check({tag, ".key_find"}, {6'd0, key_find}, {6'd0, e.k});
            check({tag, ".life"}, {6'd0, life}, {6'd0, e.l});
            check({tag, ".todo"}, {6'd0, todo}, {6'd0, e.t});
            check({tag, ".play_valid"}, {4'd0, play_valid}, {4'd0, e.pv});
        end
    endtask

    task automatic click_at(input logic [8:0] x, input logic [8:0] y, input string tag);
        drive(1'b1, x, y, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic pulse(input logic k, input logic l, input logic d, input logic h, input string tag);
        drive(1'b0, 9'd0, 9'd0, k, l, d, h, 1'b0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            pulse(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic three_keys(input string tag);
        for (int i = 1; i <= 3; i++) begin
            e_key = 2'(i);
            if (i == 3) e_todo = 2'd3;
            pulse(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("%s_key%0d", tag, i));
        end
    endtask

    task automatic expect_stage(input logic [3:0] st);
        e_state = st;
        e_key   = 2'd0;
        e_life  = 2'd3;
        e_todo  = (st == 4'd4) ? 2'd2 : 2'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0; rst = 1'b0; click = 1'b0; mouse_x = '0; mouse_y = '0;
        key_pulse = 1'b0; light_pulse = 1'b0; door_pulse = 1'b0; hit_pulse = 1'b0;
        e_state = 4'd0; e_key = 2'd0; e_life = 2'd0; e_todo = 2'd0; e_pv = 4'b0010;

        drive(1'b0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
        click_at(9'd130, 9'd165, "title_locked_s2");
        click_at(9'd200, 9'd125, "title_x_edge_miss");
        expect_stage(4'd2);
        click_at(9'd130, 9'd125, "enter_s1");

        three_keys("s1");
        pulse(1'b1, 1'b0, 1'b0, 1'b0, "s1_key4_sat");
        click_at(9'd130, 9'd145, "s1_click_ignored");
        e_state = 4'd3; e_todo = 2'd0; e_pv = 4'b0110;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, "s1_door");
        pulse(1'b1, 1'b0, 1'b0, 1'b1, "succ1_pulses_ignored");

        expect_stage(4'd4);
        click_at(9'd130, 9'd145, "succ1_next");
        pulse(1'b1, 1'b0, 1'b0, 1'b0, "s2_key_early");
        e_todo = 2'd1;
        pulse(1'b0, 1'b1, 1'b0, 1'b0, "s2_light");
        three_keys("s2");
        e_state = 4'd5; e_todo = 2'd0; e_pv = 4'b1110;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, "s2_door");

        expect_stage(4'd6);
        click_at(9'd150, 9'd145, "succ2_next");
        e_life = 2'd2;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, "hit_c0");
        idle(1, "inv_c1");
        pulse(1'b0, 1'b0, 1'b0, 1'b1, "hit_c2_ignored");
        idle(1, "inv_c3");
        e_life = 2'd1;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, "hit_c4");
        idle(3, "inv_c5_7");
        e_state = 4'd8; e_life = 2'd0; e_todo = 2'd0;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, "hit_c8_fatal");

        expect_stage(4'd6);
        click_at(9'd150, 9'd145, "fail_retry");
        three_keys("s3");
        e_life = 2'd2;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, "s3_hit_a");
        idle(3, "s3_inv_a");
        e_life = 2'd1;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, "s3_hit_b");
        idle(3, "s3_inv_b");
        e_state = 4'd8; e_life = 2'd0; e_todo = 2'd0;
        pulse(1'b0, 1'b0, 1'b1, 1'b1, "fatal_hit_vs_door");

        expect_stage(4'd6);
        click_at(9'd150, 9'd145, "retry2");
        e_life = 2'd2;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, "pre_reset_hit");
        e_state = 4'd0; e_key = 2'd0; e_life = 2'd0; e_todo = 2'd0; e_pv = 4'b0010;
        drive(1'b1, 9'd130, 9'd125, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "mid_stage_reset");

        expect_stage(4'd2);
        click_at(9'd130, 9'd125, "run2_s1");
        three_keys("r2s1");
        e_state = 4'd3; e_todo = 2'd0; e_pv = 4'b0110;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, "r2s1_door");
        e_state = 4'd0;
        click_at(9'd130, 9'd185, "succ1_back");
        expect_stage(4'd4);
        click_at(9'd130, 9'd165, "title_s2_unlocked");
        e_todo = 2'd1;
        pulse(1'b0, 1'b1, 1'b0, 1'b0, "r2s2_light");
        three_keys("r2s2");
        e_state = 4'd5; e_todo = 2'd0; e_pv = 4'b1110;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, "r2s2_door");
        expect_stage(4'd6);
        click_at(9'd150, 9'd145, "r2_next_s3");
        three_keys("r2s3");
        e_state = 4'd7; e_todo = 2'd0;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, "r2s3_door");
        e_state = 4'd1;
        click_at(9'd150, 9'd160, "succ3_next_staff");
        click_at(9'd200, 9'd185, "staff_x200_miss");
        e_state = 4'd0;
        click_at(9'd199, 9'd185, "staff_x199_back");
        expect_stage(4'd6);
        click_at(9'd130, 9'd205, "title_s3_unlocked");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
